mux_n_reg_arb: RTL and testbench

- Parametrised successor to the plain 2:1 vector mux: selects one of N input channels, each W bits wide, into a single registered output.
- Every channel and the output use a valid/ready handshake.
- Two selection modes:
  - MODE=0: fixed select, channel chosen by S.
  - MODE=1: round-robin arbitration over the valid channels.
- Sits between multiple producers and one consumer stage, replacing combinational Mux2xW trees where timing or flow control is needed.

---
 rtl/mux_n_reg_arb_if.sv | 29 ++
 rtl/mux_n_reg_arb.sv | 95 +++++++++
 tb/tb_mux_n_reg_arb.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mux_n_reg_arb_if.sv
// Handshake bundle for the N-channel registered mux/arbiter.
// Signal names follow the block's published pin names.
interface mux_n_reg_arb_if #(
   parameter int N  = 2,
   parameter int W  = 4,
   parameter int SW = (N > 1) ? $clog2(N) : 1
);
   logic [N*W-1:0] I;
   logic [N-1:0]   I_VALID;
   logic [N-1:0]   I_READY;
   logic [SW-1:0]  S;
   logic           MODE;
   logic [W-1:0]   O;
   logic           O_VALID;
   logic           O_READY;
   logic [SW-1:0]  GRANT;

   // Arbiter side
   modport slave (
      input  I, I_VALID, S, MODE, O_READY,
      output I_READY, O, O_VALID, GRANT
   );

   // Producer/consumer side
   modport master (
      output I, I_VALID, S, MODE, O_READY,
      input  I_READY, O, O_VALID, GRANT
   );
endinterface

// File: rtl/mux_n_reg_arb.sv
// N-channel registered mux with fixed-select or round-robin grant.
// One output register stage; ready is combinational from grant and load.
module mux_n_reg_arb #(
   parameter int N  = 2,
   parameter int W  = 4,
   parameter int SW = (N > 1) ? $clog2(N) : 1
) (
   input logic              CLK,
   input logic              ASYNCRESETN,
   mux_n_reg_arb_if.slave   bus
);

   logic [W-1:0]  o_q,       o_d;
   logic          o_valid_q, o_valid_d;
   logic [SW-1:0] grant_q,   grant_d;
   logic [SW-1:0] ptr_q,     ptr_d;

   logic          load;
   logic          gnt_vld;
   logic [SW-1:0] gnt;
   logic [N-1:0]  ready;
   logic          xfer;
   int            idx;

   assign load = !o_valid_q || bus.O_READY;

   // Grant: fixed S in mode 0, first valid after the pointer in mode 1.
   // The loop walks from farthest to nearest so the nearest hit wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      idx     = 0;
      if (!bus.MODE) begin
         if (int'(bus.S) < N) begin
            gnt_vld = 1'b1;
            gnt     = bus.S;
         end
      end else begin
         for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (bus.I_VALID[idx]) begin
               gnt_vld = 1'b1;
               gnt     = SW'(idx);
            end
         end
      end
   end

   // Ready only to the granted channel, and never while reset is held.
   always_comb begin
      ready = '0;
      if (gnt_vld && ASYNCRESETN)
         ready[gnt] = load;
   end

   assign xfer = gnt_vld && bus.I_VALID[gnt] && ready[gnt];

   // Next state: refill on transfer, otherwise drain when the consumer takes the word.
   always_comb begin
      o_d       = o_q;
      o_valid_d = o_valid_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      if (xfer) begin
         o_d       = bus.I[int'(gnt)*W +: W];
         o_valid_d = 1'b1;
         grant_d   = gnt;
         if (bus.MODE)
            ptr_d = gnt;
      end else if (bus.O_READY) begin
         o_valid_d = 1'b0;
      end
   end

   // Output register and round-robin pointer; pointer resets to N-1 so channel 0 wins first.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         o_q       <= '0;
         o_valid_q <= 1'b0;
         grant_q   <= '0;
         ptr_q     <= SW'(N - 1);
      end else begin
         o_q       <= o_d;
         o_valid_q <= o_valid_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
      end
   end

   assign bus.I_READY = ready;
   assign bus.O       = o_q;
   assign bus.O_VALID = o_valid_q;
   assign bus.GRANT   = grant_q;

endmodule

// File: tb/tb_mux_n_reg_arb.sv
// Directed bench for mux_n_reg_arb: a 4x8 instance for the main plan and
// a 6x8 instance for the non-power-of-two select range.
module tb_mux_n_reg_arb;

   logic CLK = 1'b0;
   logic ASYNCRESETN;
   int   n_vec = 0;
   int   n_err = 0;

   mux_n_reg_arb_if #(.N(4), .W(8), .SW(2)) b4();
   mux_n_reg_arb_if #(.N(6), .W(8), .SW(3)) b6();

   mux_n_reg_arb #(.N(4), .W(8), .SW(2)) u4 (
      .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(b4.slave)
   );
   mux_n_reg_arb #(.N(6), .W(8), .SW(3)) u6 (
      .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(b6.slave)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   int exp_g[4] = '{3, 1, 3, 1};

   initial begin
      ASYNCRESETN = 1'b0;
      b4.I        = 32'h40302010;
      b4.I_VALID  = 4'b1111;
      b4.S        = 2'd0;
      b4.MODE     = 1'b0;
      b4.O_READY  = 1'b1;
      b6.I        = 48'h605040302010;
      b6.I_VALID  = '0;
      b6.S        = 3'd0;
      b6.MODE     = 1'b0;
      b6.O_READY  = 1'b1;

      // Reset values, ready gated while reset is held
      #2;
      chk("rst_o",     b4.O,       0);
      chk("rst_ov",    b4.O_VALID, 0);
      chk("rst_grant", b4.GRANT,   0);
      chk("rst_ready", b4.I_READY, 0);
      tick();
      #2 ASYNCRESETN = 1'b1;

      // Fixed select S=2
      b4.S = 2'd2;
      #1 chk("fix_ready", b4.I_READY, 4'b0100);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fix_o",     b4.O,       8'h30);
         chk("fix_grant", b4.GRANT,   2);
         chk("fix_ov",    b4.O_VALID, 1);
      end

      // Asynchronous reset mid-cycle while holding a word
      #3 ASYNCRESETN = 1'b0;
      #1;
      chk("arst_o",     b4.O,       0);
      chk("arst_ov",    b4.O_VALID, 0);
      chk("arst_grant", b4.GRANT,   0);
      chk("arst_ready", b4.I_READY, 0);
      #1 ASYNCRESETN = 1'b1;

      // Round-robin fairness from reset pointer N-1
      b4.MODE = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rr_grant", b4.GRANT, i % 4);
         chk("rr_o",     b4.O,     ((i % 4) + 1) * 16);
      end

      // Round-robin skip over channels 0 and 2
      b4.I_VALID = 4'b1010;
      tick();
      chk("skip_first", b4.GRANT, 1);
      for (int i = 0; i < 4; i++) begin
         chk("skip_ready", b4.I_READY, 32'(1) << exp_g[i]);
         tick();
         chk("skip_grant", b4.GRANT, exp_g[i]);
      end

      // Back-pressure with a held 0x55
      b4.MODE    = 1'b0;
      b4.S       = 2'd1;
      b4.I       = 32'h40305510;
      b4.I_VALID = 4'b1111;
      tick();
      chk("bp_load", b4.O, 8'h55);
      b4.O_READY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         b4.I_VALID  = (i % 2 == 1) ? 4'b0101 : 4'b1111;
         b4.I[15:8]  = 8'(8'h60 + i);
         #1 chk("bp_ready", b4.I_READY, 0);
         tick();
         chk("bp_o",     b4.O,       8'h55);
         chk("bp_ov",    b4.O_VALID, 1);
         chk("bp_grant", b4.GRANT,   1);
      end
      b4.I_VALID = 4'b1111;
      b4.I[15:8] = 8'h77;
      b4.O_READY = 1'b1;
      #1 chk("bp_rel_ready", b4.I_READY, 4'b0010);
      tick();
      chk("bp_rel_o",  b4.O,       8'h77);
      chk("bp_rel_ov", b4.O_VALID, 1);

      // Mode switch: pointer to 2, three fixed transfers, then round-robin resumes at 3
      b4.I       = 32'h40302010;
      b4.MODE    = 1'b1;
      b4.I_VALID = 4'b0100;
      tick();
      chk("ms_ptr2", b4.GRANT, 2);
      b4.MODE    = 1'b0;
      b4.S       = 2'd0;
      b4.I_VALID = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ms_fix_grant", b4.GRANT, 0);
         chk("ms_fix_o",     b4.O,     8'h10);
      end
      b4.MODE = 1'b1;
      #1 chk("ms_ready", b4.I_READY, 4'b1000);
      tick();
      chk("ms_grant", b4.GRANT, 3);
      chk("ms_o",     b4.O,     8'h40);

      // Drain without refill: O and GRANT hold
      b4.I_VALID = 4'b0000;
      #1 chk("dr_ready", b4.I_READY, 0);
      tick();
      chk("dr_ov",    b4.O_VALID, 0);
      chk("dr_o",     b4.O,       8'h40);
      chk("dr_grant", b4.GRANT,   3);

      // N=6: S=5 with channel 5 idle, then S=6 out of range
      b6.I_VALID = 6'b111111;
      tick();
      chk("n6_o",  b6.O,       8'h10);
      chk("n6_ov", b6.O_VALID, 1);
      b6.S       = 3'd5;
      b6.I_VALID = 6'b011111;
      #1 chk("n6_s5_ready", b6.I_READY, 6'b100000);
      tick();
      chk("n6_s5_ov", b6.O_VALID, 0);
      chk("n6_s5_o",  b6.O,       8'h10);
      b6.S       = 3'd3;
      b6.I_VALID = 6'b111111;
      tick();
      chk("n6_s3_o", b6.O, 8'h40);
      b6.S = 3'd6;
      #1 chk("n6_s6_ready", b6.I_READY, 0);
      tick();
      chk("n6_s6_ov",    b6.O_VALID, 0);
      chk("n6_s6_grant", b6.GRANT,   3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
